// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo front end: opcode encodings, instruction
// field positions and the decoded queue entry.
package tomasulo_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;

  typedef enum logic [1:0] {
    ISSUE_ADD = 2'd0,
    ISSUE_SUB = 2'd1,
    ISSUE_MUL = 2'd2,
    ISSUE_ILL = 2'd3
  } issue_op_e;

  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RS1_LSB = 8;
  localparam int unsigned RS2_LSB = 4;
  localparam int unsigned RD_LSB  = 0;

  typedef struct packed {
    issue_op_e  op;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
    logic [3:0] pc;
  } entry_t;

  function automatic entry_t decode(input logic [15:0] instr, input logic [3:0] pc);
    entry_t e;
    case (instr[OPC_LSB +: 4])
      OP_ADD:  e.op = ISSUE_ADD;
      OP_SUB:  e.op = ISSUE_SUB;
      OP_MUL:  e.op = ISSUE_MUL;
      default: e.op = ISSUE_ILL;
    endcase
    e.rs1 = instr[RS1_LSB +: 4];
    e.rs2 = instr[RS2_LSB +: 4];
    e.rd  = instr[RD_LSB +: 4];
    e.pc  = pc;
    return e;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; DEPTH must be a power of two
// so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    head_q, tail_q;
  logic [AW:0]      count_q;

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[tail_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + 1'b1;
      if (pop_i)  head_q <= head_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[head_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/fetch_issue_queue.sv
// Fetch/decode front end: drives the PC to instruction memory, decodes the
// returned word and queues it for in-order issue to the reservation stations.
module fetch_issue_queue
  import tomasulo_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PROG_LEN = 6
) (
  input  logic        clk1,
  input  logic        rst_n,
  output logic [3:0]  pc,
  input  logic [15:0] instr_in,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [1:0]  issue_op,
  output logic [3:0]  issue_rs1,
  output logic [3:0]  issue_rs2,
  output logic [3:0]  issue_rd,
  output logic [3:0]  issue_pc,
  output logic        done
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C    = (AW+1)'(DEPTH);
  localparam logic [4:0]  PROG_LEN_C = 5'(PROG_LEN);

  logic [3:0]  pc_q, pc_d;
  logic [4:0]  pc_count_q, pc_count_d;
  logic        pending_q, pending_d;
  logic [3:0]  pending_pc_q, pending_pc_d;
  logic        done_q;
  logic        fetch_en, pop, empty;
  logic [AW:0] count, credit;
  entry_t      wr_entry, head;

  // Credit ignores a same-cycle pop so queue plus in-flight fetch never exceeds DEPTH.
  always_comb begin
    credit       = count + {{AW{1'b0}}, pending_q};
    fetch_en     = (pc_count_q < PROG_LEN_C) && (credit < DEPTH_C);
    pc_d         = pc_q;
    pc_count_d   = pc_count_q;
    pending_pc_d = pending_pc_q;
    pending_d    = 1'b0;
    if (fetch_en) begin
      pc_d         = pc_q + 4'd1;
      pc_count_d   = pc_count_q + 5'd1;
      pending_pc_d = pc_q;
      pending_d    = 1'b1;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= '0;
      pc_count_q   <= '0;
      pending_q    <= 1'b0;
      pending_pc_q <= '0;
      done_q       <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      pc_count_q   <= pc_count_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
      if ((pc_count_q == PROG_LEN_C) && !pending_q && (count == '0)) done_q <= 1'b1;
    end
  end

  assign wr_entry    = decode(instr_in, pending_pc_q);
  assign issue_valid = !empty;
  assign pop         = issue_valid && issue_ready;

  sync_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk1),
    .rst_ni (rst_n),
    .push_i (pending_q),
    .pop_i  (pop),
    .wdata_i(wr_entry),
    .rdata_o(head),
    .empty_o(empty),
    .count_o(count)
  );

  // Storage is not reset, so fields are forced to zero whenever the queue is empty.
  always_comb begin
    issue_op  = '0;
    issue_rs1 = '0;
    issue_rs2 = '0;
    issue_rd  = '0;
    issue_pc  = '0;
    if (issue_valid) begin
      issue_op  = head.op;
      issue_rs1 = head.rs1;
      issue_rs2 = head.rs2;
      issue_rd  = head.rd;
      issue_pc  = head.pc;
    end
  end

  assign pc   = pc_q;
  assign done = done_q;

endmodule

// File: tb/tb_fetch_issue_queue.sv
// Directed bench: two queue instances (PROG_LEN 6 and 16) fed from one
// instruction memory model, checked against a hand-written issue table.
module tb_fetch_issue_queue;

  typedef struct {
    logic [15:0] instr;
    logic [1:0]  op;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
  } vec_t;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_ready = 1'b0;
  logic [15:0] mem [16];
  logic [15:0] instr_a, instr_b;

  logic [3:0] pc_a, rs1_a, rs2_a, rd_a, ipc_a, pc_b, rs1_b, rs2_b, rd_b, ipc_b;
  logic [1:0] op_a, op_b;
  logic       v_a, v_b, done_a, done_b;

  logic [3:0] g_pc, g_rs1, g_rs2, g_rd, g_ipc;
  logic [1:0] g_op;
  logic       g_v, g_done;

  vec_t exp_tab [16];
  int   checks = 0;
  int   errors = 0;
  int   sel = 0;

  always #5 clk1 = ~clk1;

  always @(posedge clk1) begin
    instr_a <= mem[pc_a];
    instr_b <= mem[pc_b];
  end

  fetch_issue_queue #(.DEPTH(4), .PROG_LEN(6)) dut (
    .clk1(clk1), .rst_n(rst_n), .pc(pc_a), .instr_in(instr_a),
    .issue_valid(v_a), .issue_ready(issue_ready), .issue_op(op_a),
    .issue_rs1(rs1_a), .issue_rs2(rs2_a), .issue_rd(rd_a),
    .issue_pc(ipc_a), .done(done_a)
  );

  fetch_issue_queue #(.DEPTH(4), .PROG_LEN(16)) dut16 (
    .clk1(clk1), .rst_n(rst_n), .pc(pc_b), .instr_in(instr_b),
    .issue_valid(v_b), .issue_ready(issue_ready), .issue_op(op_b),
    .issue_rs1(rs1_b), .issue_rs2(rs2_b), .issue_rd(rd_b),
    .issue_pc(ipc_b), .done(done_b)
  );

  always_comb begin
    if (sel == 0) begin
      g_pc = pc_a; g_v = v_a; g_op = op_a; g_rs1 = rs1_a;
      g_rs2 = rs2_a; g_rd = rd_a; g_ipc = ipc_a; g_done = done_a;
    end else begin
      g_pc = pc_b; g_v = v_b; g_op = op_b; g_rs1 = rs1_b;
      g_rs2 = rs2_b; g_rd = rd_b; g_ipc = ipc_b; g_done = done_b;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // mode 0: ready held high; 1: ready low for 10 cycles then high; 2: ready toggles 1,0,1,0
  task automatic run(input int mode, input int nexp, input bit check_done, input int plen);
    int idx = 0;
    int cyc = 0;
    int first = -1;
    @(negedge clk1);
    rst_n = 1'b0;
    issue_ready = 1'b0;
    #1;
    check("reset_outputs", {g_pc, g_v, g_op, g_rs1, g_rs2, g_rd, g_ipc, g_done}, '0);
    @(negedge clk1);
    rst_n = 1'b1;
    while (idx < nexp && cyc < 300) begin
      @(negedge clk1);
      cyc++;
      issue_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc > 10) : cyc[0];
      if (mode == 1 && cyc == 10) check("stall_pc_valid", {g_pc, g_v}, {4'd4, 1'b1});
      if (g_v) begin
        if (first < 0) first = cyc;
        check($sformatf("issue%0d", idx), {g_op, g_rs1, g_rs2, g_rd, g_ipc},
              {exp_tab[idx].op, exp_tab[idx].rs1, exp_tab[idx].rs2, exp_tab[idx].rd, 4'(idx)});
        if (issue_ready) idx++;
      end
    end
    if (idx < nexp) check("timeout_issues", idx, nexp);
    if (mode == 0) check("first_valid_cycle", first, 2);
    if (check_done) begin
      @(negedge clk1);
      check("done_before", {g_v, g_done}, 2'b00);
      @(negedge clk1);
      check("done_after", {g_v, g_done}, 2'b01);
      repeat (4) @(negedge clk1);
      check("end_state", {g_pc, g_v, g_done}, {4'(plen), 1'b0, 1'b1});
    end
  endtask

  initial begin
    vec_t saved;
    exp_tab[0] = '{16'h2123, 2'd2, 4'd1,  4'd2,  4'd3};
    exp_tab[1] = '{16'h0345, 2'd0, 4'd3,  4'd4,  4'd5};
    exp_tab[2] = '{16'h0267, 2'd0, 4'd2,  4'd6,  4'd7};
    exp_tab[3] = '{16'h089A, 2'd0, 4'd8,  4'd9,  4'd10};
    exp_tab[4] = '{16'h27AB, 2'd2, 4'd7,  4'd10, 4'd11};
    exp_tab[5] = '{16'h1B56, 2'd1, 4'd11, 4'd5,  4'd6};
    for (int i = 6; i < 16; i++)
      exp_tab[i] = '{{4'h1, 4'(i), 4'(15 - i), 4'(i)}, 2'd1, 4'(i), 4'(15 - i), 4'(i)};
    for (int i = 0; i < 16; i++) mem[i] = exp_tab[i].instr;

    repeat (2) @(negedge clk1);

    sel = 0;
    run(0, 6, 1'b1, 6);
    run(1, 6, 1'b1, 6);
    run(2, 6, 1'b1, 6);

    saved      = exp_tab[2];
    exp_tab[2] = '{16'hF123, 2'd3, 4'd1, 4'd2, 4'd3};
    mem[2]     = 16'hF123;
    run(0, 6, 1'b1, 6);
    exp_tab[2] = saved;
    mem[2]     = saved.instr;

    run(0, 3, 1'b0, 6);
    run(0, 6, 1'b1, 6);

    sel = 1;
    run(0, 16, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_issue_queue.md
# fetch_issue_queue

Fetch-and-issue front end that sits directly downstream of the instruction memory. It drives the 4-bit PC into the memory, captures the 16-bit instruction returned one clock later, and decodes it into opcode and register fields. Decoded instructions are buffered in a small in-order FIFO and presented one at a time, with a valid/ready handshake, to the Tomasulo issue logic (reservation-station allocation).

## Interface
Parameters:
- DEPTH, 4, FIFO entries (power of two, 2..8)
- PROG_LEN, 6, number of instructions fetched from address 0 before fetch stops (1..16)

Ports:
- clk1  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- pc  out  4  fetch address driven to instruction memory (registered)
- instr_in  in  16  instruction from memory; reflects memory[pc] sampled at the previous rising edge
- issue_valid  out  1  head entry is valid
- issue_ready  in  1  issue logic accepts head this cycle
- issue_op  out  2  0=add, 1=sub, 2=mul, 3=illegal
- issue_rs1  out  4  instr[11:8]
- issue_rs2  out  4  instr[7:4]
- issue_rd  out  4  instr[3:0]
- issue_pc  out  4  address the head instruction was fetched from
- done  out  1  all PROG_LEN instructions issued and queue empty

## Operation
- Decode: instr[15:12] 0000→add, 0001→sub, 0010→mul, any other→illegal (3). Illegal entries are queued and issued like any other; the issue logic decides what to do with them.
- fetch_en = (pc_count < PROG_LEN) && (count + pending < DEPTH). pc_count is a 5-bit count of fetches launched, so PROG_LEN=16 terminates without 4-bit wrap.
- On an edge with fetch_en: pending←1, pending_pc←pc, pc←pc+1 (4-bit; wraps 15→0 only after the final fetch, and is never used again), pc_count←pc_count+1. On an edge without fetch_en: pending←0.
- On an edge with pending=1: write {decoded op, rs1, rs2, rd, pending_pc} from instr_in to the tail.
- Pop when issue_valid && issue_ready. Push and pop in the same cycle leave count unchanged. Push into an empty FIFO while popping is impossible because issue_valid is 0 when empty.
- Credit is conservative: the same-cycle pop does not count toward fetch_en, so the FIFO plus the in-flight fetch never exceeds DEPTH and no entry is lost.
- Outputs come from the head entry (show-ahead). issue_* fields are held stable while issue_valid=1 and issue_ready=0.
- done is registered. It goes to 1 when pc_count==PROG_LEN, pending=0 and count=0, then stays high until reset.

## Timing
- Reset (async assert, sync effect on release): pc=0, pc_count=0, pending=0, count=0, head=tail=0, issue_valid=0, issue_op/rs1/rs2/rd/issue_pc=0, done=0.
- Latency: with rst_n released before edge E0, fetch of address 0 launches at E0, the entry is written at E1, and issue_valid=1 after E1. Fetch-to-issue_valid is 2 edges.
- Steady state: one instruction per cycle when issue_ready is held at 1.
- Reset mid-operation immediately clears all state; the in-flight fetch is discarded. Fetch restarts from pc=0 at the first edge after release.
- Stall: the first edge at which count+pending reaches DEPTH stops fetch. Fetch resumes the cycle after a pop frees credit.

## Structure
- Shared package (tomasulo_pkg): opcode constants OP_ADD=4'b0000, OP_SUB=4'b0001, OP_MUL=4'b0010; the 2-bit issue op encoding; field bit positions; the decoded-entry struct {op, rs1, rs2, rd, pc}.
- One sub-module: sync_fifo (parameterised width/depth, show-ahead, count output). fetch_issue_queue holds the PC/credit logic and the decoder.

## Test plan
- Reset, issue_ready=1, default program (mul r3 r1 r2; add r5 r3 r4; add r7 r2 r6; add r10 r8 r9; mul r11 r7 r10; sub r6 r11 r5) → issue_valid at edge 2. Six consecutive issues: op 2,0,0,0,2,1; rd 3,5,7,10,11,6; issue_pc 0..5. done=1 one edge after the last pop.
- issue_ready=0 throughout → count reaches 4 and pc stops at 4. Head stays op=2, rs1=1, rs2=2, rd=3. Raising ready drains all six in order.
- Toggle issue_ready 1,0,1,0 → every instruction issued exactly once and in order. Fields stay stable while stalled.
- memory[2]=16'hF123 → third issue has op=3, rs1=1, rs2=2, rd=3, issue_pc=2.
- Assert rst_n low after 3 issues, release → all outputs 0 during reset. Reissue starts at issue_pc=0.
- PROG_LEN=16, ready=1 → 16 issues with issue_pc 0..15, no 17th fetch, done=1.
